// File: rtl/clock_pkg.sv
// Shared types and limits for the digital clock timekeeping path.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX. clr beats inc, but the
// wrap flag still reports an inc at MAX so a carry is never lost.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic wrap
);

  localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
  localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;
  logic at_max;

  // Next value: clear, wrap at MAX, or BCD increment with tens carry.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    tens_d = tens_q;
    ones_d = ones_q;
    at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    wrap   = inc && at_max;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and edit controller: BCD HH:MM:SS, one-second prescaler,
// RUN/SET_HOUR/SET_MIN mode FSM, blink of the edited field, colon drive.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int BLINK_HALF    = 25000000,
  parameter int WIDTH         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_mode,
  input  logic                  btn_inc,
  output logic [3:0][WIDTH-1:0] digit_value,
  output logic [3:0]            blank,
  output logic                  colon,
  output logic [1:0]            mode
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  logic in_run, in_set_hour, in_set_min, sec_tick, edit_inc;
  logic sec_clr, sec_inc, min_inc, hour_inc;
  logic sec_wrap, min_wrap;
  // Hours roll 23 -> 00 inside their counter; nothing sits above hours.
  logic hour_wrap_unused;
  // Seconds tens are never displayed; only sec_ones drives the colon.
  bcd_t sec_tens_unused;
  bcd_t sec_ones, min_tens, min_ones, hour_tens, hour_ones;

  // Counter controls: a mode pulse swallows a same-cycle inc, and in the
  // set modes the edited field increments without carrying upward.
  always_comb begin
    in_run      = (state_q == RUN);
    in_set_hour = (state_q == SET_HOUR);
    in_set_min  = (state_q == SET_MIN);
    sec_tick    = (presc_q == PRESC_LAST);
    edit_inc    = btn_inc && !btn_mode;
    sec_clr     = in_run && btn_mode;
    sec_inc     = in_run && sec_tick;
    min_inc     = in_run ? sec_wrap : (in_set_min && edit_inc);
    hour_inc    = in_run ? min_wrap : (in_set_hour && edit_inc);
  end

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .clr(sec_clr), .inc(sec_inc),
    .tens(sec_tens_unused), .ones(sec_ones), .wrap(sec_wrap)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(min_inc),
    .tens(min_tens), .ones(min_ones), .wrap(min_wrap)
  );

  bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(hour_inc),
    .tens(hour_tens), .ones(hour_ones), .wrap(hour_wrap_unused)
  );

  // Mode FSM, prescaler and blink next-state.
  always_comb begin
    state_d       = state_q;
    presc_d       = sec_tick ? '0 : presc_q + PW'(1);
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;

    if (btn_mode) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN: begin
          state_d = RUN;
          // First second after an edit is a full second.
          presc_d = '0;
        end
        default:  state_d = RUN;
      endcase
    end

    // Any press restarts the blink with the field lit; RUN holds it at 0.
    if (!in_run && !btn_mode && !btn_inc) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      presc_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Display outputs decoded purely from registers.
  always_comb begin
    digit_value[3] = WIDTH'(hour_tens);
    digit_value[2] = WIDTH'(hour_ones);
    digit_value[1] = WIDTH'(min_tens);
    digit_value[0] = WIDTH'(min_ones);
    blank          = 4'b0000;
    if (in_set_hour && blink_phase_q) blank = 4'b1100;
    if (in_set_min && blink_phase_q)  blank = 4'b0011;
    colon          = in_run ? ~sec_ones[0] : 1'b1;
    mode           = state_q;
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICKS_PER_SEC=4, BLINK_HALF=2.
module tb_clock_time_ctrl;
  import clock_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            btn_mode;
  logic            btn_inc;
  logic [3:0][3:0] digit_value;
  logic [3:0]      blank;
  logic            colon;
  logic [1:0]      mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clock_time_ctrl #(
    .TICKS_PER_SEC(4),
    .BLINK_HALF   (2),
    .WIDTH        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .digit_value(digit_value),
    .blank      (blank),
    .colon      (colon),
    .mode       (mode)
  );

  // Press record: pulse pattern, repeat count, expected state afterwards.
  typedef struct {
    logic        b_mode;
    logic        b_inc;
    int          reps;
    logic [1:0]  exp_mode;
    logic [15:0] exp_hhmm;
    logic        exp_colon;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle pulse followed by one idle cycle.
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step();
  endtask

  task automatic apply_vec(input int k);
    repeat (vecs[k].reps) press(vecs[k].b_mode, vecs[k].b_inc);
    check($sformatf("v%0d mode", k), 32'(mode), 32'(vecs[k].exp_mode));
    check($sformatf("v%0d hhmm", k), 32'(digit_value), 32'(vecs[k].exp_hhmm));
    check($sformatf("v%0d blank", k), 32'(blank), 32'h0);
    check($sformatf("v%0d colon", k), 32'(colon), 32'(vecs[k].exp_colon));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1,  RUN,      16'h0001, 1'b1}; // inc ignored in RUN
    vecs[1]  = '{1'b1, 1'b0, 1,  SET_HOUR, 16'h0001, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 25, SET_HOUR, 16'h0101, 1'b1}; // 25 mod 24
    vecs[3]  = '{1'b0, 1'b1, 22, SET_HOUR, 16'h2301, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1,  SET_MIN,  16'h2301, 1'b1}; // mode wins
    vecs[5]  = '{1'b0, 1'b1, 58, SET_MIN,  16'h2359, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1,  SET_MIN,  16'h2300, 1'b1}; // no hour carry
    vecs[7]  = '{1'b0, 1'b1, 59, SET_MIN,  16'h2359, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1,  RUN,      16'h2359, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1,  SET_HOUR, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 9,  SET_HOUR, 16'h0900, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1,  SET_MIN,  16'h0900, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 59, SET_MIN,  16'h0959, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1,  RUN,      16'h0959, 1'b1};

    // Reset held for two cycles.
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step();
    step();
    check("rst hhmm", 32'(digit_value), 32'h0);
    check("rst blank", 32'(blank), 32'h0);
    check("rst colon", 32'(colon), 32'h1);
    check("rst mode", 32'(mode), 32'(RUN));
    rst = 1'b0;

    // Free run: seconds = n/4, colon on in even seconds.
    for (int n = 1; n <= 240; n++) begin
      step();
      check($sformatf("run colon n=%0d", n), 32'(colon), 32'(((n / 4) % 2) == 0));
      if (n == 239) check("run hhmm 00:00:59", 32'(digit_value), 32'h0000);
      if (n == 240) check("run hhmm 00:01", 32'(digit_value), 32'h0001);
    end

    // Edit to 23:59, return to RUN, roll over the day.
    for (int k = 0; k <= 8; k++) apply_vec(k);
    repeat (238) step();
    check("pre rollover 23:59", 32'(digit_value), 32'h2359);
    step();
    check("rollover 00:00", 32'(digit_value), 32'h0000);

    // Edit to 09:59, check the BCD tens carry into hours.
    for (int k = 9; k <= 13; k++) apply_vec(k);
    repeat (238) step();
    check("pre carry 09:59", 32'(digit_value), 32'h0959);
    step();
    check("carry 10:00", 32'(digit_value), 32'h1000);

    // Blink in SET_MIN: 0000/0011 alternating every 2 cycles.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("blink mode", 32'(mode), 32'(SET_MIN));
    check("blink start", 32'(blank), 32'h0);
    for (int j = 1; j <= 9; j++) begin
      step();
      check($sformatf("blink j=%0d", j), 32'(blank),
            ((((j + 1) / 2) % 2) == 1) ? 32'h3 : 32'h0);
    end
    // Inc during phase 1 lights the digits at once and bumps the minute.
    btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
    check("inc in blink blank", 32'(blank), 32'h0);
    check("inc in blink hhmm", 32'(digit_value), 32'h1001);

    // Set 12:34 (checking the hour blink on the way), then reset mid-edit.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (2) press(1'b0, 1'b1);
    step();
    check("hour blink", 32'(blank), 32'hC);
    check("hour set 12", 32'(digit_value), 32'h1201);
    press(1'b1, 1'b0);
    repeat (33) press(1'b0, 1'b1);
    check("edit mode", 32'(mode), 32'(SET_MIN));
    check("edit 12:34", 32'(digit_value), 32'h1234);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rst mode", 32'(mode), 32'(RUN));
    check("mid rst hhmm", 32'(digit_value), 32'h0);
    check("mid rst blank", 32'(blank), 32'h0);
    check("mid rst colon", 32'(colon), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
